// File: rtl/traffic_light_multi.sv
// rtl/traffic_light_multi.sv - multi-approach traffic light sequencer with actuated skipping and flashing-yellow mode
module traffic_light_multi #(
  parameter int NUM_DIRS       = 2,
  parameter int GREEN_CYCLES   = 30,
  parameter int YELLOW_CYCLES  = 5,
  parameter int RED_RED_CYCLES = 3,
  parameter int FLASH_CYCLES   = 8,
  parameter int ACTUATED       = 0,
  localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES,
  localparam int MAX_RF = (RED_RED_CYCLES > FLASH_CYCLES) ? RED_RED_CYCLES : FLASH_CYCLES,
  localparam int MAX_C  = (MAX_GY > MAX_RF) ? MAX_GY : MAX_RF,
  localparam int CW     = $clog2(MAX_C) + 1,
  localparam int DW     = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flash,
  input  logic [NUM_DIRS-1:0] req,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic [DW-1:0]       active_dir,
  output logic [1:0]          phase
);

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2,
    PH_FLASH   = 2'd3
  } phase_t;

  phase_t              phase_q, n_phase;
  logic [DW-1:0]       dir_q, n_dir, sel_dir;
  logic [CW-1:0]       cnt_q, n_cnt;
  logic                tog_q, n_tog;
  logic [NUM_DIRS-1:0] pending, n_pending;
  logic [NUM_DIRS-1:0] demand, n_red, n_yellow, n_green;
  logic                other_pending, found;

  // Demand seen this clock includes the live req so a pulse can release a held green immediately.
  always_comb begin
    demand        = (ACTUATED != 0) ? (pending | req) : '0;
    other_pending = |(demand & ~(NUM_DIRS'(1) << dir_q));
    found         = 1'b0;
    sel_dir       = dir_q;
    if (ACTUATED != 0) begin
      for (int k = 1; k <= NUM_DIRS; k++) begin
        if (!found && demand[(int'(dir_q) + k) % NUM_DIRS]) begin
          found   = 1'b1;
          sel_dir = DW'((int'(dir_q) + k) % NUM_DIRS);
        end
      end
    end else begin
      sel_dir = DW'((int'(dir_q) + 1) % NUM_DIRS);
    end
  end

  always_comb begin
    n_phase   = phase_q;
    n_dir     = dir_q;
    n_cnt     = cnt_q + CW'(1);
    n_tog     = tog_q;
    n_pending = demand;
    case (phase_q)
      PH_GREEN: begin
        if (cnt_q == CW'(GREEN_CYCLES - 1)) begin
          if ((ACTUATED != 0) && !other_pending) begin
            n_cnt = cnt_q;
          end else begin
            n_phase = PH_YELLOW;
            n_cnt   = '0;
          end
        end
      end
      PH_YELLOW: begin
        if (cnt_q == CW'(YELLOW_CYCLES - 1)) begin
          n_phase = PH_ALL_RED;
          n_cnt   = '0;
        end
      end
      PH_ALL_RED: begin
        if (cnt_q == CW'(RED_RED_CYCLES - 1)) begin
          n_cnt = '0;
          if (flash) begin
            n_phase = PH_FLASH;
            n_tog   = 1'b1;
          end else begin
            n_phase   = PH_GREEN;
            n_dir     = sel_dir;
            n_pending = demand & ~(NUM_DIRS'(1) << sel_dir);
          end
        end
      end
      default: begin
        if (!flash) begin
          n_phase = PH_ALL_RED;
          n_cnt   = '0;
        end else if (cnt_q == CW'(FLASH_CYCLES - 1)) begin
          n_cnt = '0;
          n_tog = ~tog_q;
        end
      end
    endcase
  end

  // Lamps are decoded from next state so the registered outputs line up with the registered phase.
  always_comb begin
    n_red    = '0;
    n_yellow = '0;
    n_green  = '0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (n_phase == PH_FLASH) begin
        n_yellow[i] = n_tog;
      end else if (n_phase == PH_ALL_RED || DW'(i) != n_dir) begin
        n_red[i] = 1'b1;
      end else if (n_phase == PH_GREEN) begin
        n_green[i] = 1'b1;
      end else begin
        n_yellow[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      pending <= '0;
      green   <= NUM_DIRS'(1);
      red     <= ~NUM_DIRS'(1);
      yellow  <= '0;
    end else begin
      phase_q <= n_phase;
      dir_q   <= n_dir;
      cnt_q   <= n_cnt;
      tog_q   <= n_tog;
      pending <= n_pending;
      green   <= n_green;
      red     <= n_red;
      yellow  <= n_yellow;
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// tb/tb_traffic_light_multi.sv - directed bench for fixed and actuated traffic_light_multi
module tb_traffic_light_multi;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic       rst_f = 1'b1, flash_f = 1'b0;
  logic [2:0] req_f = 3'b000;
  logic [2:0] red_f, yellow_f, green_f;
  logic [1:0] dir_f, phase_f;

  logic       rst_a = 1'b1, flash_a = 1'b0;
  logic [2:0] req_a = 3'b000;
  logic [2:0] red_a, yellow_a, green_a;
  logic [1:0] dir_a, phase_a;

  traffic_light_multi #(
    .NUM_DIRS(3), .GREEN_CYCLES(30), .YELLOW_CYCLES(5),
    .RED_RED_CYCLES(3), .FLASH_CYCLES(8), .ACTUATED(0)
  ) dut_f (
    .clk(clk), .rst(rst_f), .flash(flash_f), .req(req_f),
    .red(red_f), .yellow(yellow_f), .green(green_f),
    .active_dir(dir_f), .phase(phase_f)
  );

  traffic_light_multi #(
    .NUM_DIRS(3), .GREEN_CYCLES(30), .YELLOW_CYCLES(5),
    .RED_RED_CYCLES(3), .FLASH_CYCLES(8), .ACTUATED(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .flash(flash_a), .req(req_a),
    .red(red_a), .yellow(yellow_a), .green(green_a),
    .active_dir(dir_a), .phase(phase_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic inv_ok(input logic [2:0] r, input logic [2:0] y, input logic [2:0] g);
    int nonred = 0;
    logic ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ((32'(r[i]) + 32'(y[i]) + 32'(g[i])) != 1) ok = 1'b0;
      if (!r[i]) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    return ok;
  endfunction

  always @(negedge clk) begin
    if (phase_f != 2'd3) chk("inv_fixed", 32'(inv_ok(red_f, yellow_f, green_f)), 32'd1);
    if (phase_a != 2'd3) chk("inv_act", 32'(inv_ok(red_a, yellow_a, green_a)), 32'd1);
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic reset_f();
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    cyc = 0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // fixed round-robin
    reset_f();
    chk("t1_rst_green", 32'(green_f), 32'h1);
    chk("t1_rst_red", 32'(red_f), 32'h6);
    chk("t1_rst_yellow", 32'(yellow_f), 32'h0);
    chk("t1_rst_phase", 32'(phase_f), 32'd0);
    run_to(29);  chk("t1_g29", 32'(green_f), 32'h1);
    run_to(30);  chk("t1_y30", 32'(yellow_f), 32'h1);
    chk("t1_ph30", 32'(phase_f), 32'd1);
    run_to(34);  chk("t1_y34", 32'(yellow_f), 32'h1);
    run_to(35);  chk("t1_ar35", 32'(red_f), 32'h7);
    chk("t1_ph35", 32'(phase_f), 32'd2);
    run_to(37);  chk("t1_ph37", 32'(phase_f), 32'd2);
    run_to(38);  chk("t1_g38", 32'(green_f), 32'h2);
    chk("t1_dir38", 32'(dir_f), 32'd1);
    run_to(75);  chk("t1_ph75", 32'(phase_f), 32'd2);
    run_to(76);  chk("t1_g76", 32'(green_f), 32'h4);
    chk("t1_dir76", 32'(dir_f), 32'd2);
    run_to(114); chk("t1_g114", 32'(green_f), 32'h1);
    chk("t1_dir114", 32'(dir_f), 32'd0);

    // actuated: skip approach 1
    reset_a();
    run_to(10);
    req_a = 3'b100;
    tick();
    req_a = 3'b000;
    chk("t2_pend11", 32'(dut_a.pending), 32'h4);
    run_to(29);  chk("t2_g29", 32'(green_a), 32'h1);
    run_to(30);  chk("t2_y30", 32'(yellow_a), 32'h1);
    run_to(38);  chk("t2_g38", 32'(green_a), 32'h4);
    chk("t2_dir38", 32'(dir_a), 32'd2);
    run_to(39);  chk("t2_pend39", 32'(dut_a.pending), 32'h0);

    // actuated: green hold then release
    reset_a();
    run_to(200);
    chk("t3_g200", 32'(green_a), 32'h1);
    chk("t3_r200", 32'(red_a), 32'h6);
    chk("t3_ph200", 32'(phase_a), 32'd0);
    req_a = 3'b010;
    tick();
    req_a = 3'b000;
    chk("t3_y201", 32'(yellow_a), 32'h1);
    chk("t3_ph201", 32'(phase_a), 32'd1);
    run_to(208); chk("t3_ph208", 32'(phase_a), 32'd2);
    run_to(209); chk("t3_g209", 32'(green_a), 32'h2);
    chk("t3_dir209", 32'(dir_a), 32'd1);

    // flash entry through clearance, toggle, exit
    reset_f();
    run_to(15);
    flash_f = 1'b1;
    run_to(29);  chk("t4_g29", 32'(green_f), 32'h1);
    run_to(30);  chk("t4_y30", 32'(yellow_f), 32'h1);
    run_to(35);  chk("t4_ar35", 32'(red_f), 32'h7);
    run_to(38);  chk("t4_ph38", 32'(phase_f), 32'd3);
    chk("t4_y38", 32'(yellow_f), 32'h7);
    chk("t4_r38", 32'(red_f), 32'h0);
    chk("t4_g38", 32'(green_f), 32'h0);
    run_to(45);  chk("t4_y45", 32'(yellow_f), 32'h7);
    run_to(46);  chk("t4_y46", 32'(yellow_f), 32'h0);
    run_to(53);  chk("t4_y53", 32'(yellow_f), 32'h0);
    run_to(54);  chk("t4_y54", 32'(yellow_f), 32'h7);
    flash_f = 1'b0;
    run_to(55);  chk("t4_ph55", 32'(phase_f), 32'd2);
    chk("t4_r55", 32'(red_f), 32'h7);
    run_to(57);  chk("t4_ph57", 32'(phase_f), 32'd2);
    run_to(58);  chk("t4_g58", 32'(green_f), 32'h2);
    chk("t4_dir58", 32'(dir_f), 32'd1);

    // reset mid-yellow
    reset_f();
    run_to(32);
    chk("t5_ph32", 32'(phase_f), 32'd1);
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    chk("t5_g33", 32'(green_f), 32'h1);
    chk("t5_r33", 32'(red_f), 32'h6);
    chk("t5_y33", 32'(yellow_f), 32'h0);
    chk("t5_ph33", 32'(phase_f), 32'd0);
    chk("t5_dir33", 32'(dir_f), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
Parametrised successor to the two-way fixed-time controller. Sequences NUM_DIRS conflicting approaches through green, yellow and all-red clearance in round-robin order. Optionally skips approaches with no pending demand (actuated mode) and supports a flashing-yellow night/fault mode entered only through a safe clearance. Sits at the top of the intersection design, driving the lamp drivers directly.

Parameters:
NUM_DIRS, 2, number of conflicting approaches (>=2)
GREEN_CYCLES, 30, clocks per green interval (>=1)
YELLOW_CYCLES, 5, clocks per yellow interval (>=1)
RED_RED_CYCLES, 3, clocks of all-red clearance (>=1)
FLASH_CYCLES, 8, clocks per half-period of the flashing yellow (>=1)
ACTUATED, 0, 0 = fixed round-robin; 1 = demand-driven skipping
CW, derived, counter width = clog2 of the largest cycle parameter, plus 1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
flash  in  1  level request for flashing-yellow mode
req  in  NUM_DIRS  per-approach demand pulses/levels (used only when ACTUATED=1)
red  out  NUM_DIRS  red lamp per approach
yellow  out  NUM_DIRS  yellow lamp per approach
green  out  NUM_DIRS  green lamp per approach
active_dir  out  clog2(NUM_DIRS)  approach currently served
phase  out  2  0=GREEN 1=YELLOW 2=ALL_RED 3=FLASH

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset state: phase GREEN, active_dir 0, cnt 0, pending 0, flash toggle 0. Outputs: green[0]=1; red=1 on all other approaches; yellow=0.
- Interval counter cnt counts 0..LEN-1. A phase ends on the clock where cnt==LEN-1, and cnt returns to 0. Each phase is therefore visible for exactly LEN clocks.
- GREEN (LEN=GREEN_CYCLES) -> YELLOW (LEN=YELLOW_CYCLES) -> ALL_RED (LEN=RED_RED_CYCLES) -> GREEN on the next approach.
- Lamps per approach:
  - GREEN/YELLOW: the active approach shows green/yellow; all others show red.
  - ALL_RED: all approaches red.
  - FLASH: red=0, green=0, and all yellow bits equal the flash toggle.
- Invariant: outside FLASH, exactly one of red/yellow/green is set per approach, and at most one approach is non-red.
- Next-approach selection, evaluated at the end of ALL_RED:
  - ACTUATED=0: (active_dir+1) mod NUM_DIRS.
  - ACTUATED=1: first approach with a pending bit set, searching circularly from active_dir+1. If none is pending, the next approach is active_dir.
- Demand handling (ACTUATED=1):
  - pending |= req every clock.
  - The pending bit of an approach clears on the clock its green starts. A req asserted for the served approach during its own green is kept.
- Green hold (ACTUATED=1): at the end of GREEN, if no other approach is pending, GREEN is held. It re-evaluates every clock with cnt saturated at GREEN_CYCLES-1, and leaves on the first clock another approach has a pending bit.
- Flash entry:
  - flash is sampled only at the end of ALL_RED. If high, go to FLASH instead of GREEN.
  - A flash request during GREEN does not shorten the green; the normal yellow and all-red still complete first.
- In FLASH, the toggle inverts every FLASH_CYCLES clocks, starting with yellow lit.
- Flash exit: on the clock flash is sampled low in FLASH, go to ALL_RED for a full RED_RED_CYCLES, then select the next approach normally.
- rst asserted in any phase, including mid-yellow and mid-flash, returns to the reset state on the next clock edge. No clearance is applied.
- req and flash are synchronous to clk; no internal synchronisers.

Test Plan:
1. NUM_DIRS=3, ACTUATED=0, params 30/5/3. Release rst at cycle 0 -> green=001 for cycles 0-29, yellow=001 for 30-34, all-red 35-37, green=010 at 38, green=100 at 76, green=001 at 114.
2. ACTUATED=1, NUM_DIRS=3. Pulse req[2] at cycle 10 -> approach 0 yellow at 30, approach 2 green at 38 (approach 1 skipped); pending[2] is 0 at cycle 39.
3. ACTUATED=1, no req -> approach 0 stays green past cycle 200 with red=110. Pulse req[1] at cycle 200 -> yellow=001 at 201, green=010 at 209.
4. flash raised at cycle 15 in phase GREEN -> green continues to 29, yellow 30-34, all-red 35-37, phase=FLASH at 38 with yellow=111 for 8 clocks, then 000 for 8. Drop flash -> 3 clocks all-red, then green on the next approach.
5. Assert rst for 1 clock mid-yellow (cycle 32) -> cycle 33 outputs green=001, red=110, phase=0, active_dir=0.
6. Checker runs every clock in all tests: the non-FLASH one-hot-per-approach invariant and at most one non-red approach.
